// File: rtl/riscv_v_pkg.sv
// Shared types for the vector arithmetic write-back collector.
// Optional feature macro: RISCV_V_WB_SAT_FLAG_EN (keeps overflow flags in the FIFO entry).
package riscv_v_pkg;

    localparam int RVV_DATA_W      = 128;
    localparam int RVV_NUM_BYTES   = RVV_DATA_W / 8;
    localparam int RVV_VREG_ADDR_W = 5;

    // One-hot element size, bit0 = 8-bit elements
    typedef enum logic [3:0] {
        OSIZE_8  = 4'b0001,
        OSIZE_16 = 4'b0010,
        OSIZE_32 = 4'b0100,
        OSIZE_64 = 4'b1000
    } osize_t;

    typedef struct packed {
        logic [RVV_DATA_W-1:0]      data;
        logic [RVV_NUM_BYTES-1:0]   zf;
`ifdef RISCV_V_WB_SAT_FLAG_EN
        logic [RVV_NUM_BYTES-1:0]   of;
`endif
        logic [RVV_NUM_BYTES-1:0]   cf;
        osize_t                     osize;
        logic                       mask_mode;
        logic [RVV_VREG_ADDR_W-1:0] vd;
        logic                       last;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH
    } wb_state_t;

    // Elements carried by one beat for a given element size
    function automatic logic [4:0] osize_to_elems(input osize_t osize);
        case (osize)
            OSIZE_16: return 5'(RVV_NUM_BYTES / 2);
            OSIZE_32: return 5'(RVV_NUM_BYTES / 4);
            OSIZE_64: return 5'(RVV_NUM_BYTES / 8);
            default:  return 5'(RVV_NUM_BYTES);
        endcase
    endfunction

    // Gather the flag of each element's most significant byte into bit k for element k
    function automatic logic [RVV_NUM_BYTES-1:0] elem_msb_bits(input logic [RVV_NUM_BYTES-1:0] flags,
                                                             input osize_t osize);
        logic [RVV_NUM_BYTES-1:0] bits;
        bits = '0;
        case (osize)
            OSIZE_16: for (int k = 0; k < RVV_NUM_BYTES / 2; k++) bits[k] = flags[2*k+1];
            OSIZE_32: for (int k = 0; k < RVV_NUM_BYTES / 4; k++) bits[k] = flags[4*k+3];
            OSIZE_64: for (int k = 0; k < RVV_NUM_BYTES / 8; k++) bits[k] = flags[8*k+7];
            default:  bits = flags;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/riscv_v_wb_fifo.sv
// Generic registered FIFO; full/empty are registered, so a pop never frees a slot
// for a push in the same cycle. DEPTH must be a power of two.
module riscv_v_wb_fifo #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign head    = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // Control state is reset; payload storage is not
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload storage
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/riscv_v_arith_wb_collector.sv
// Vector ALU write-back collector: buffers ALU beats, writes data beats to the VRF,
// and packs carry/borrow bits of mask-mode instructions into one mask register write.
// Optional feature macro: RISCV_V_WB_SAT_FLAG_EN (sticky sat_flag output, sat_clr input).
module riscv_v_arith_wb_collector
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH  = RVV_DATA_W,
    parameter int NUM_BYTES   = RVV_NUM_BYTES,
    parameter int FIFO_DEPTH  = 2,
    parameter int MAX_BEATS   = 8,
    parameter int VREG_ADDR_W = RVV_VREG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_BYTES-1:0]   in_zf,
    input  logic [NUM_BYTES-1:0]   in_of,
    input  logic [NUM_BYTES-1:0]   in_cf,
    input  logic [3:0]             in_osize,
    input  logic                   in_mask_mode,
    input  logic [VREG_ADDR_W-1:0] in_vd,
    input  logic                   in_last,
    output logic                   vrf_we,
    input  logic                   vrf_ready,
    output logic [VREG_ADDR_W-1:0] vrf_addr,
    output logic [DATA_WIDTH-1:0]  vrf_wdata,
    output logic [NUM_BYTES-1:0]   vrf_be,
    output logic                   busy
`ifdef RISCV_V_WB_SAT_FLAG_EN
    ,
    input  logic                   sat_clr,
    output logic                   sat_flag
`endif
);

    localparam int P_MAX = MAX_BEATS * NUM_BYTES;
    localparam int P_W   = $clog2(P_MAX + 1);

    wb_entry_t              in_entry, fifo_head;
    logic                   fifo_full, fifo_empty, fifo_pop;
    wb_state_t              state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [P_W-1:0]         p_q, p_d;
    logic [P_W:0]           p_sum;
    logic [VREG_ADDR_W-1:0] flush_vd_q, flush_vd_d;
    logic [NUM_BYTES-1:0]   head_cf_bits;
    logic [DATA_WIDTH-1:0]  keep_mask;

    // Pack the incoming beat into a FIFO entry
    always_comb begin
        in_entry           = '0;
        in_entry.data      = in_data;
        in_entry.zf        = in_zf;
`ifdef RISCV_V_WB_SAT_FLAG_EN
        in_entry.of        = in_of;
`endif
        in_entry.cf        = in_cf;
        in_entry.osize     = osize_t'(in_osize);
        in_entry.mask_mode = in_mask_mode;
        in_entry.vd        = in_vd;
        in_entry.last      = in_last;
    end

    riscv_v_wb_fifo #(
        .entry_t (wb_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready     = !fifo_full;
    assign busy         = !fifo_empty || (state_q != ST_IDLE);
    assign head_cf_bits = elem_msb_bits(fifo_head.cf, fifo_head.osize);
    assign keep_mask    = (int'(p_q) >= DATA_WIDTH) ? '1 : ~({DATA_WIDTH{1'b1}} << p_q);

    // Collector control: data pass-through, mask accumulation and the final mask flush
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        p_d        = p_q;
        flush_vd_d = flush_vd_q;
        fifo_pop   = 1'b0;
        vrf_we     = 1'b0;
        vrf_addr   = '0;
        vrf_wdata  = '0;
        vrf_be     = '0;
        p_sum      = {1'b0, p_q} + (P_W+1)'(osize_to_elems(fifo_head.osize));
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (fifo_head.mask_mode) begin
                        state_d = ST_ACCUM;
                    end else begin
                        vrf_we    = 1'b1;
                        vrf_addr  = fifo_head.vd;
                        vrf_wdata = fifo_head.data;
                        vrf_be    = '1;
                        fifo_pop  = vrf_ready;
                    end
                end
            end
            ST_ACCUM: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Bits landing at or beyond DATA_WIDTH shift out and are dropped
                    acc_d    = acc_q | ({{(DATA_WIDTH-NUM_BYTES){1'b0}}, head_cf_bits} << p_q);
                    p_d      = (p_sum > (P_W+1)'(P_MAX)) ? P_W'(P_MAX) : p_sum[P_W-1:0];
                    if (fifo_head.last) begin
                        state_d    = ST_FLUSH;
                        flush_vd_d = fifo_head.vd;
                    end
                end
            end
            ST_FLUSH: begin
                vrf_we    = 1'b1;
                vrf_addr  = flush_vd_q;
                vrf_wdata = acc_q & keep_mask;
                vrf_be    = '1;
                if (vrf_ready) begin
                    acc_d   = '0;
                    p_d     = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset discards any partial mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    // Destination of the pending mask write
    always_ff @(posedge clk) begin
        flush_vd_q <= flush_vd_d;
    end

`ifdef RISCV_V_WB_SAT_FLAG_EN
    logic sat_flag_q, sat_flag_d;
    logic sat_pend_q, sat_pend_d;
    logic sat_set;
    logic head_of_hit;
    logic unused_flags;

    assign head_of_hit  = |elem_msb_bits(fifo_head.of, fifo_head.osize);
    assign sat_flag     = sat_flag_q;
    assign unused_flags = ^fifo_head.zf;

    // Overflow at an element MSB sets the sticky flag when its beat commits; set beats clear
    always_comb begin
        sat_set    = 1'b0;
        sat_pend_d = sat_pend_q;
        case (state_q)
            ST_IDLE:  sat_set = !fifo_empty && !fifo_head.mask_mode && vrf_ready && head_of_hit;
            ST_ACCUM: if (!fifo_empty) sat_pend_d = sat_pend_q | head_of_hit;
            ST_FLUSH: if (vrf_ready) begin
                sat_set    = sat_pend_q;
                sat_pend_d = 1'b0;
            end
            default:  sat_pend_d = 1'b0;
        endcase
        sat_flag_d = sat_set ? 1'b1 : (sat_clr ? 1'b0 : sat_flag_q);
    end

    // Sticky saturation flag and the overflow summary of a mask in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag_q <= 1'b0;
            sat_pend_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
            sat_pend_q <= sat_pend_d;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{in_of, fifo_head.zf};
`endif

`ifndef SYNTHESIS
    // A data-mode beat must never reach the head while a mask is being packed
    mode_change_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == ST_ACCUM && !fifo_empty && !fifo_head.mask_mode))
        else $error("data-mode beat at FIFO head during mask accumulation");
`endif

endmodule
